// File: rtl/csa_seq_adder_if.sv
// Operand/result handshake bundle for csa_seq_adder.
// master = producer/consumer side, slave = the sequencer.
interface csa_seq_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_sub;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, op_a, op_b, op_sub, cin, out_ready,
        input  in_ready, out_valid, result, cout, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, op_sub, cin, out_ready,
        output in_ready, out_valid, result, cout, busy
    );
endinterface

// File: rtl/csa_seq_adder.sv
// Multi-precision add/subtract: one 4-bit carry-select adder reused per nibble,
// LS nibble first, carry chained through a register.
module csa_seq_adder #(
    parameter int unsigned WIDTH = 16
) (
    input logic            clk,
    input logic            rst,
    csa_seq_adder_if.slave bus
);
    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, res_q;
    logic              carry_q, cout_q;
    logic [IDXW-1:0]   idx_q;
    logic              last;

    logic [3:0] csa_a, csa_b, csa_sum;
    logic       csa_co;
    logic [2:0] lo, hi0, hi1;

    assign last  = (idx_q == IDXW'(NIB - 1));
    assign csa_a = a_q[{idx_q, 2'b00} +: 4];
    assign csa_b = b_q[{idx_q, 2'b00} +: 4];

    // Carry-select nibble adder: upper half precomputed for both carries, picked by lower carry
    always_comb begin
        lo      = {1'b0, csa_a[1:0]} + {1'b0, csa_b[1:0]} + {2'b00, carry_q};
        hi0     = {1'b0, csa_a[3:2]} + {1'b0, csa_b[3:2]};
        hi1     = {1'b0, csa_a[3:2]} + {1'b0, csa_b[3:2]} + 3'd1;
        csa_sum = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
        csa_co  = lo[2] ? hi1[2] : hi0[2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.in_valid)  state_d = StRun;
            StRun:   if (last)          state_d = StDone;
            StDone:  if (bus.out_ready) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.op_a;
                        // Subtract as A + ~B + 1
                        b_q     <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry_q <= bus.op_sub ? 1'b1 : bus.cin;
                        idx_q   <= '0;
                        res_q   <= '0;
                        cout_q  <= 1'b0;
                    end
                end
                StRun: begin
                    res_q[{idx_q, 2'b00} +: 4] <= csa_sum;
                    carry_q                    <= csa_co;
                    if (last) begin
                        cout_q <= csa_co;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.result    = res_q;
    assign bus.cout      = cout_q;
endmodule
